// File: rtl/cpu_divider.sv
// Iterative 32-bit divide/modulo unit: restoring shift-subtract on operand magnitudes,
// result returned as a one-cycle pulse tagged with its destination register.
module cpu_divider #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        div_start,
    input  logic [1:0]  div_op,
    input  logic [31:0] div_numerator,
    input  logic [31:0] div_denominator,
    input  logic [4:0]  div_dest_in,
    output logic        div_busy,
    output logic        div_valid,
    output logic [31:0] div_result,
    output logic [4:0]  div_dest_reg,
    output logic [1:0]  div_state
);

    localparam int ITERS = 32 / BITS_PER_CYCLE;

    // Handshake: div_start is honoured only in a cycle where div_busy=0; div_valid is a
    // single-cycle pulse with no ready/backpressure, so the consumer must take it then.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  dest_q, dest_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] den_q, den_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  dest_out_q, dest_out_d;
    logic        valid_q, valid_d;

    logic        a_neg, b_neg;
    logic [31:0] rem_t, quo_t, quo_fin, rem_fin;
    logic [32:0] shifted, trial;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dest_d     = dest_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        den_d      = den_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        dest_out_d = dest_out_q;
        valid_d    = 1'b0;
        a_neg      = div_op[0] & div_numerator[31];
        b_neg      = div_op[0] & div_denominator[31];
        rem_t      = rem_q;
        quo_t      = quo_q;
        shifted    = '0;
        trial      = '0;
        quo_fin    = neg_quo_q ? (32'd0 - quo_q) : quo_q;
        rem_fin    = neg_rem_q ? (32'd0 - rem_q) : rem_q;

        // Remainder stays below the divisor, so the 33-bit trial never overflows.
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            shifted = {rem_t, quo_t[31]};
            quo_t   = {quo_t[30:0], 1'b0};
            trial   = shifted - {1'b0, den_q};
            if (!trial[32]) begin
                rem_t    = trial[31:0];
                quo_t[0] = 1'b1;
            end else begin
                rem_t = shifted[31:0];
            end
        end

        case (state_q)
            IDLE: begin
                if (div_start) begin
                    op_d      = div_op;
                    dest_d    = div_dest_in;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    quo_d     = a_neg ? (32'd0 - div_numerator) : div_numerator;
                    den_d     = b_neg ? (32'd0 - div_denominator) : div_denominator;
                    rem_d     = '0;
                    cnt_d     = 5'(ITERS - 1);
                    state_d   = RUN;
                end
            end
            RUN: begin
                rem_d = rem_t;
                quo_d = quo_t;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = FINISH;
            end
            FINISH: begin
                // Divide by zero leaves rem=|a| (so MOD returns a) but the quotient is forced.
                if (op_q[1])               result_d = rem_fin;
                else if (den_q == 32'd0)   result_d = 32'hFFFF_FFFF;
                else                       result_d = quo_fin;
                dest_out_d = dest_q;
                valid_d    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            dest_q     <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            den_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            dest_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dest_q     <= dest_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            den_q      <= den_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            dest_out_q <= dest_out_d;
            valid_q    <= valid_d;
        end
    end

    assign div_busy     = (state_q != IDLE);
    assign div_valid    = valid_q;
    assign div_result   = result_q;
    assign div_dest_reg = dest_out_q;
    assign div_state    = state_q;

endmodule

// File: tb/tb_cpu_divider.sv
// Self-checking bench for cpu_divider: reference model feeds an expected queue,
// each scenario task waits for div_valid and compares inline.
module tb_cpu_divider;

    localparam int LAT = 33;   // edges after the sampling edge until div_valid is visible

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        div_start = 1'b0;
    logic [1:0]  div_op = '0;
    logic [31:0] div_numerator = '0;
    logic [31:0] div_denominator = '0;
    logic [4:0]  div_dest_in = '0;
    logic        div_busy, div_valid;
    logic [31:0] div_result;
    logic [4:0]  div_dest_reg;
    logic [1:0]  div_state;

    logic [36:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    cpu_divider #(.BITS_PER_CYCLE(1)) dut (
        .clock(clock), .reset_n(reset_n), .div_start(div_start), .div_op(div_op),
        .div_numerator(div_numerator), .div_denominator(div_denominator),
        .div_dest_in(div_dest_in), .div_busy(div_busy), .div_valid(div_valid),
        .div_result(div_result), .div_dest_reg(div_dest_reg), .div_state(div_state)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int  sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'd0:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd1:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            2'd2:    return (b == 0) ? a : a % b;
            default: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
        endcase
    endfunction

    // Called #1 after a rising edge; start is sampled on the next rising edge.
    task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] dest);
        div_op          = op;
        div_numerator   = a;
        div_denominator = b;
        div_dest_in     = dest;
        div_start       = 1'b1;
        exp_q.push_back({dest, model(op, a, b)});
        @(posedge clock);
        #1;
        div_start = 1'b0;
    endtask

    task automatic wait_valid(output int edges, output int busy_cycles, output bit timed_out);
        edges       = 0;
        busy_cycles = div_busy ? 1 : 0;
        timed_out   = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clock);
            #1;
            edges++;
            if (div_valid) begin
                timed_out = 1'b0;
                break;
            end
            if (div_busy) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({div_busy, div_valid, div_result, div_dest_reg, div_state} !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b valid=%0b result=%h dest=%0d state=%0d, want all 0",
                     div_busy, div_valid, div_result, div_dest_reg, div_state);
        end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_basic();
        int e, bc;
        bit to;
        logic [36:0] exp;
        drive_op(2'd0, 32'd100, 32'd7, 5'd5);
        wait_valid(e, bc, to);
        exp = exp_q.pop_front();
        checks++;
        if (to || {div_dest_reg, div_result} !== exp) begin
            errors++;
            $display("FAIL basic_divu: timeout=%0b got dest=%0d res=%h, want dest=%0d res=%h",
                     to, div_dest_reg, div_result, exp[36:32], exp[31:0]);
        end
        checks++;
        if (e != LAT) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges, want %0d", e, LAT);
        end
        checks++;
        if (bc != LAT || div_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: busy cycles %0d busy_in_valid=%0b, want %0d and 0", bc, div_busy, LAT);
        end
        @(posedge clock);
        #1;
        checks++;
        if (div_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width: valid=%0b one cycle later, want 0", div_valid);
        end
    endtask

    task automatic test_table(input string name, input logic [1:0] ops[4], input logic [31:0] as[4],
                              input logic [31:0] bs[4], input int n);
        int e, bc;
        bit to;
        logic [36:0] exp;
        for (int i = 0; i < n; i++) begin
            drive_op(ops[i], as[i], bs[i], 5'(i + 1));
            wait_valid(e, bc, to);
            exp = exp_q.pop_front();
            checks++;
            if (to || e != LAT || {div_dest_reg, div_result} !== exp) begin
                errors++;
                $display("FAIL %s[%0d]: timeout=%0b edges=%0d dest=%0d res=%h, want edges=%0d dest=%0d res=%h",
                         name, i, to, e, div_dest_reg, div_result, LAT, exp[36:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_signed();
        logic [1:0]  ops[4] = '{2'd1, 2'd3, 2'd3, 2'd1};
        logic [31:0] as[4]  = '{32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C};
        logic [31:0] bs[4]  = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        test_table("signed", ops, as, bs, 4);
    endtask

    task automatic test_div_zero();
        logic [1:0]  ops[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [31:0] as[4]  = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
        logic [31:0] bs[4]  = '{32'd0, 32'd0, 32'd0, 32'd0};
        test_table("div_zero", ops, as, bs, 4);
    endtask

    task automatic test_overflow();
        logic [1:0]  ops[4] = '{2'd1, 2'd3, 2'd0, 2'd2};
        logic [31:0] as[4]  = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        test_table("overflow", ops, as, bs, 4);
    endtask

    task automatic test_back_to_back();
        int e, bc;
        bit to;
        logic [36:0] exp;
        drive_op(2'd0, 32'd5000, 32'd3, 5'd9);
        wait_valid(e, bc, to);
        exp = exp_q.pop_front();
        checks++;
        if (to || {div_dest_reg, div_result} !== exp) begin
            errors++;
            $display("FAIL b2b_first: dest=%0d res=%h, want dest=%0d res=%h",
                     div_dest_reg, div_result, exp[36:32], exp[31:0]);
        end
        drive_op(2'd2, 32'd5000, 32'd3, 5'd0);
        wait_valid(e, bc, to);
        exp = exp_q.pop_front();
        checks++;
        if (to || e != LAT || {div_dest_reg, div_result} !== exp) begin
            errors++;
            $display("FAIL b2b_second: timeout=%0b edges=%0d dest=%0d res=%h, want edges=%0d dest=%0d res=%h",
                     to, e, div_dest_reg, div_result, LAT, exp[36:32], exp[31:0]);
        end
    endtask

    task automatic test_ignored_start();
        int e, bc, extra;
        bit to;
        logic [36:0] exp;
        drive_op(2'd1, 32'hFFFF_D8F0, 32'd13, 5'd17);
        repeat (5) @(posedge clock);
        #1;
        div_op = 2'd2; div_numerator = 32'd77; div_denominator = 32'd5; div_dest_in = 5'd30;
        div_start = 1'b1;
        @(posedge clock);
        #1;
        div_start = 1'b0;
        wait_valid(e, bc, to);
        exp = exp_q.pop_front();
        checks++;
        if (to || {div_dest_reg, div_result} !== exp) begin
            errors++;
            $display("FAIL ignored_start_result: dest=%0d res=%h, want dest=%0d res=%h",
                     div_dest_reg, div_result, exp[36:32], exp[31:0]);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (div_valid || div_busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ignored_start_no_second_op: %0d active cycles, want 0", extra);
        end
    endtask

    task automatic test_reset_mid_op();
        int e, bc, seen;
        bit to;
        logic [36:0] exp;
        drive_op(2'd0, 32'hDEAD_BEEF, 32'd3, 5'd12);
        repeat (10) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({div_busy, div_valid, div_result, div_dest_reg, div_state} !== 41'd0) begin
            errors++;
            $display("FAIL reset_mid_op_outputs: busy=%0b valid=%0b res=%h dest=%0d state=%0d, want all 0",
                     div_busy, div_valid, div_result, div_dest_reg, div_state);
        end
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        seen = 0;
        repeat (50) begin
            @(posedge clock);
            #1;
            if (div_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_op_no_valid: %0d valid pulses, want 0", seen);
        end
        drive_op(2'd0, 32'd1000, 32'd10, 5'd3);
        wait_valid(e, bc, to);
        exp = exp_q.pop_front();
        checks++;
        if (to || e != LAT || {div_dest_reg, div_result} !== exp || div_result !== 32'd100) begin
            errors++;
            $display("FAIL reset_mid_op_restart: timeout=%0b edges=%0d res=%h, want edges=%0d res=%h",
                     to, e, div_result, LAT, 32'd100);
        end
    endtask

    task automatic test_random();
        int e, bc;
        bit to;
        logic [36:0] exp;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(1, 15);
                1:       b = 32'd0 - $urandom_range(1, 15);
                2:       b = $urandom_range(0, 1) ? 32'd0 : 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            drive_op(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)));
            wait_valid(e, bc, to);
            exp = exp_q.pop_front();
            checks++;
            if (to || e != LAT || {div_dest_reg, div_result} !== exp) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h op=%0d: edges=%0d dest=%0d res=%h, want dest=%0d res=%h",
                         i, a, b, div_op, e, div_dest_reg, div_result, exp[36:32], exp[31:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
